// File: rtl/logic_reduce_unit.sv
// logic_reduce_unit: folds a framed valid/ready stream of words with AND/OR/XOR/NAND into one result,
// reporting the beat count (saturating at MAX_LEN) and a sticky overflow flag per frame.
module logic_reduce_unit #(
  parameter int WIDTH = 8,
  parameter int MAX_LEN = 16,
  localparam int CW = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_count,
  output logic             out_err
);
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
  state_t           r_state, w_next;
  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  logic [WIDTH-1:0] r_acc, w_fold;
  logic [CW-1:0]    r_count;
  logic             r_err;
  logic [1:0]       r_op;
  logic             w_fire, w_sat, w_first;
  // reset asserts asynchronously but releases two clocks after rst_n rises
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rst_sync <= '0;
    else r_rst_sync <= {r_rst_sync[0], 1'b1};
  assign w_rst_n = r_rst_sync[1];
  assign w_fire  = in_valid && in_ready;
  assign w_first = r_state == IDLE;
  assign w_sat   = r_count == CW'(MAX_LEN);
  assign w_fold  = r_op == 2'b01 ? r_acc | in_data :
                   r_op == 2'b10 ? r_acc ^ in_data : r_acc & in_data;
  always_ff @(posedge clk or negedge w_rst_n)
    if (!w_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_fire ? (in_last ? HOLD : ACC) : IDLE;
      ACC:     w_next = w_fire && in_last ? HOLD : ACC;
      HOLD:    w_next = out_ready ? IDLE : HOLD;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    in_ready  = r_state != HOLD;
    out_valid = r_state == HOLD;
    out_data  = out_valid ? (r_op == 2'b11 ? ~r_acc : r_acc) : '0;
    out_count = out_valid ? r_count : '0;
    out_err   = out_valid && r_err;
  end
  // NAND folds as AND; the inversion is applied only when the result is presented
  always_ff @(posedge clk or negedge w_rst_n)
    if (!w_rst_n) begin
      r_acc   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      r_op    <= 2'b00;
    end else if (w_fire) begin
      r_acc   <= w_first ? in_data : w_fold;
      r_op    <= w_first ? op : r_op;
      r_count <= w_first ? CW'(1) : w_sat ? r_count : r_count + 1'b1;
      r_err   <= !w_first && (r_err || w_sat);
    end
endmodule

// File: tb/tb_logic_reduce_unit.sv
// tb_logic_reduce_unit: directed tests on a 1-bit instance (truth tables) and an 8-bit, MAX_LEN=4 instance.
module tb_logic_reduce_unit;
  logic       clk = 0;
  logic       rst_n = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  // 1-bit instance
  logic [1:0] a_op = 0;
  logic       a_v = 0, a_d = 0, a_l = 0, a_ordy = 1;
  logic       a_rdy, a_ov, a_od, a_oe;
  logic [4:0] a_oc;
  // 8-bit instance, MAX_LEN=4
  logic [1:0] op = 0;
  logic       v = 0, l = 0, ordy = 1;
  logic [7:0] d = 0;
  logic       rdy, ov, oe;
  logic [7:0] od;
  logic [2:0] oc;

  always #5 clk = ~clk;

  logic_reduce_unit #(.WIDTH(1), .MAX_LEN(16)) u_d1 (
    .clk(clk), .rst_n(rst_n), .op(a_op), .in_valid(a_v), .in_ready(a_rdy), .in_data(a_d),
    .in_last(a_l), .out_valid(a_ov), .out_ready(a_ordy), .out_data(a_od), .out_count(a_oc), .out_err(a_oe));

  logic_reduce_unit #(.WIDTH(8), .MAX_LEN(4)) u_d8 (
    .clk(clk), .rst_n(rst_n), .op(op), .in_valid(v), .in_ready(rdy), .in_data(d),
    .in_last(l), .out_valid(ov), .out_ready(ordy), .out_data(od), .out_count(oc), .out_err(oe));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat1(input logic [1:0] o, input logic dd, input logic last);
    a_op = o; a_d = dd; a_l = last; a_v = 1;
    tick();
    a_v = 0; a_l = 0;
  endtask

  task automatic beat(input logic [1:0] o, input logic [7:0] dd, input logic last);
    op = o; d = dd; l = last; v = 1;
    tick();
    v = 0; l = 0;
  endtask

  task automatic check_frame(input string name, input logic [7:0] ed, input logic [2:0] ec, input logic ee);
    n_tests++;
    if (ov !== 1'b1 || od !== ed || oc !== ec || oe !== ee) begin
      n_fail++;
      $display("FAIL %s: got valid=%b data=%h count=%0d err=%b, want valid=1 data=%h count=%0d err=%b",
               name, ov, od, oc, oe, ed, ec, ee);
    end
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if (ov !== 0 || od !== 0 || oc !== 0 || oe !== 0 || rdy !== 1) begin
      n_fail++;
      $display("FAIL reset_d8: got valid=%b data=%h count=%0d err=%b ready=%b, want 0/00/0/0/1", ov, od, oc, oe, rdy);
    end
    n_tests++;
    if (a_ov !== 0 || a_od !== 0 || a_oc !== 0 || a_oe !== 0 || a_rdy !== 1) begin
      n_fail++;
      $display("FAIL reset_d1: got valid=%b data=%b count=%0d err=%b ready=%b, want 0/0/0/0/1", a_ov, a_od, a_oc, a_oe, a_rdy);
    end
    rst_n = 1;
    repeat (3) tick();
  endtask

  task automatic test_truth_table();
    logic [3:0] tt [4] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111};
    logic [3:0] row;
    for (int o = 0; o < 4; o++) begin
      row = tt[o];
      for (int ab = 0; ab < 4; ab++) begin
        beat1(2'(o), ab[1], 1'b0);
        beat1(2'(o), ab[0], 1'b1);
        n_tests++;
        if (a_ov !== 1 || a_od !== row[ab] || a_oc !== 5'd2) begin
          n_fail++;
          $display("FAIL truth op=%0d ab=%0d: got valid=%b data=%b count=%0d, want 1/%b/2", o, ab, a_ov, a_od, a_oc, row[ab]);
        end
        tick();
      end
    end
  endtask

  task automatic test_and_latency();
    beat(2'b00, 8'hA5, 0);
    beat(2'b00, 8'hF0, 0);
    n_tests++;
    if (ov !== 0) begin
      n_fail++;
      $display("FAIL and_early_valid: got valid=%b, want 0", ov);
    end
    beat(2'b00, 8'hFF, 1);
    check_frame("and_frame", 8'hA0, 3'd3, 0);
    tick();
    n_tests++;
    if (ov !== 0 || rdy !== 1) begin
      n_fail++;
      $display("FAIL and_release: got valid=%b ready=%b, want 0/1", ov, rdy);
    end
  endtask

  task automatic test_op_hold();
    beat(2'b10, 8'h0F, 0);
    beat(2'b10, 8'h33, 0);
    beat(2'b00, 8'h55, 1);
    check_frame("op_held_xor", 8'h69, 3'd3, 0);
    tick();
  endtask

  task automatic test_overflow();
    beat(2'b01, 8'h01, 0);
    beat(2'b01, 8'h02, 0);
    beat(2'b01, 8'h04, 0);
    beat(2'b01, 8'h08, 1);
    check_frame("exact_max_len", 8'h0F, 3'd4, 0);
    tick();
    beat(2'b01, 8'h01, 0);
    beat(2'b01, 8'h02, 0);
    v = 0;
    repeat (3) tick();
    beat(2'b01, 8'h04, 0);
    beat(2'b01, 8'h08, 0);
    beat(2'b01, 8'h10, 0);
    beat(2'b01, 8'h20, 1);
    check_frame("overflow", 8'h3F, 3'd4, 1);
    tick();
    beat(2'b01, 8'h80, 1);
    check_frame("after_overflow", 8'h80, 3'd1, 0);
    tick();
  endtask

  task automatic test_back_to_back();
    ordy = 0;
    beat(2'b01, 8'h11, 0);
    beat(2'b01, 8'h22, 1);
    op = 2'b10; d = 8'h44; l = 1; v = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_frame("bp_stable", 8'h33, 3'd2, 0);
      n_tests++;
      if (rdy !== 0) begin
        n_fail++;
        $display("FAIL bp_ready cycle %0d: got ready=%b, want 0", i, rdy);
      end
    end
    ordy = 1;
    tick();
    n_tests++;
    if (ov !== 0 || rdy !== 1) begin
      n_fail++;
      $display("FAIL bp_release: got valid=%b ready=%b, want 0/1", ov, rdy);
    end
    tick();
    v = 0; l = 0;
    check_frame("bp_held_beat", 8'h44, 3'd1, 0);
    tick();
  endtask

  task automatic test_reset_mid();
    beat(2'b00, 8'hFF, 0);
    beat(2'b00, 8'hF0, 0);
    rst_n = 0;
    #1;
    n_tests++;
    if (ov !== 0 || od !== 0 || oc !== 0 || oe !== 0 || rdy !== 1) begin
      n_fail++;
      $display("FAIL reset_mid_frame: got valid=%b data=%h count=%0d err=%b ready=%b, want 0/00/0/0/1", ov, od, oc, oe, rdy);
    end
    rst_n = 1;
    repeat (3) tick();
    ordy = 0;
    beat(2'b01, 8'h5A, 1);
    tick();
    rst_n = 0;
    #1;
    n_tests++;
    if (ov !== 0 || od !== 0 || oc !== 0 || rdy !== 1) begin
      n_fail++;
      $display("FAIL reset_in_hold: got valid=%b data=%h count=%0d ready=%b, want 0/00/0/1", ov, od, oc, rdy);
    end
    ordy = 1;
    rst_n = 1;
    repeat (3) tick();
    beat(2'b11, 8'hC3, 1);
    check_frame("nand_after_reset", 8'h3C, 3'd1, 0);
    tick();
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_and_latency();
    test_op_hold();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
